// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: two-bank ping-pong capture of 64-point FFT output frames,
// replayed in natural bin order over a valid/ready stream. A frame that
// arrives while no bank is free is skipped and counted in DROP_CNT.
// Optional: define FFT_FRAME_BUFFER_MAG_EN to add the OUT_MAG magnitude port.
module fft_frame_buffer #(
  parameter int unsigned DW  = 19,
  parameter int unsigned AW  = 6,
  parameter int unsigned DCW = 8
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           ED,
  input  logic           RDY,
  input  logic [AW-1:0]  ADDR,
  input  logic [DW-1:0]  DOR,
  input  logic [DW-1:0]  DOI,
  input  logic           OVF1,
  input  logic           OVF2,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [DW-1:0]  OUT_R,
  output logic [DW-1:0]  OUT_I,
  output logic [AW-1:0]  OUT_IDX,
  output logic           OUT_LAST,
  output logic           OUT_OVF,
  output logic [DCW-1:0] DROP_CNT,
  output logic           BUSY
`ifdef FFT_FRAME_BUFFER_MAG_EN
  ,
  output logic [DW:0]    OUT_MAG
`endif
);

  localparam int unsigned N = 2 ** AW;
  localparam logic [AW-1:0] LastIdx = '1;
  localparam logic [AW-1:0] CntOne  = AW'(1);

  typedef enum logic [1:0] {BkFree, BkCapt, BkFull, BkRead} bank_e;
  typedef enum logic [1:0] {CapIdle, CapCapt, CapSkip} cap_e;
  typedef enum logic {RdIdle, RdRead} rd_e;

  // Both banks share one array; the bank number is the top address bit.
  logic [2*DW-1:0] mem [2*N];

  bank_e          bank_q [2];
  bank_e          bank_d [2];
  cap_e           cap_q, cap_d;
  logic           cap_bank_q, cap_bank_d;
  logic [AW-1:0]  cap_cnt_q, cap_cnt_d;
  logic [1:0]     ovf_q, ovf_d;
  logic [DCW-1:0] drop_q, drop_d;
  logic           oldest_q, oldest_d;

  rd_e            rd_q, rd_d;
  logic           rd_bank_q, rd_bank_d;
  logic [AW:0]    rd_cnt_q, rd_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  out_r_q, out_r_d;
  logic [DW-1:0]  out_i_q, out_i_d;
  logic [AW-1:0]  out_idx_q, out_idx_d;
  logic           out_last_q, out_last_d;
  logic           out_ovf_q, out_ovf_d;

  logic            mem_we;
  logic            mem_wbank;
  logic [2*DW-1:0] rd_word;
  logic            release_bank;
  logic            free0, free1, full0, full1;
  logic            xfer, start, samp_ovf, claim_bank;
  logic [DCW-1:0]  drop_inc;

  assign rd_word  = mem[{rd_bank_q, rd_cnt_q[AW-1:0]}];
  assign xfer     = out_valid_q & OUT_READY;
  assign start    = ED & RDY;
  assign samp_ovf = OVF1 | OVF2;
  assign full0    = (bank_q[0] == BkFull);
  assign full1    = (bank_q[1] == BkFull);
  assign drop_inc = (drop_q == '1) ? drop_q : drop_q + 1'b1;

  // Sample storage, addressed by bin index within the capturing bank.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[{mem_wbank, ADDR}] <= {DOR, DOI};
    end
  end

  // Next-state for bank states, capture FSM and replay FSM.
  always_comb begin
    bank_d       = bank_q;
    cap_d        = cap_q;
    cap_bank_d   = cap_bank_q;
    cap_cnt_d    = cap_cnt_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    oldest_d     = oldest_q;
    mem_we       = 1'b0;
    mem_wbank    = cap_bank_q;
    rd_d         = rd_q;
    rd_bank_d    = rd_bank_q;
    rd_cnt_d     = rd_cnt_q;
    out_valid_d  = out_valid_q;
    out_r_d      = out_r_q;
    out_i_d      = out_i_q;
    out_idx_d    = out_idx_q;
    out_last_d   = out_last_q;
    out_ovf_d    = out_ovf_q;
    release_bank = 1'b0;

    // Replay side runs first so a release is visible to the claim below.
    unique case (rd_q)
      RdIdle: begin
        if (full0 || full1) begin
          rd_bank_d         = (full0 && full1) ? oldest_q : full1;
          bank_d[rd_bank_d] = BkRead;
          rd_cnt_d          = '0;
          rd_d              = RdRead;
        end
      end
      RdRead: begin
        if (xfer && out_last_q) begin
          release_bank      = 1'b1;
          bank_d[rd_bank_q] = BkFree;
          out_valid_d       = 1'b0;
          if (bank_q[~rd_bank_q] == BkFull) begin
            // Chain straight into the waiting bank: one idle cycle between frames.
            bank_d[~rd_bank_q] = BkRead;
            rd_bank_d          = ~rd_bank_q;
            rd_cnt_d           = '0;
          end else begin
            rd_d = RdIdle;
          end
        end else if ((!out_valid_q || xfer) && !rd_cnt_q[AW]) begin
          out_r_d     = rd_word[2*DW-1:DW];
          out_i_d     = rd_word[DW-1:0];
          out_idx_d   = rd_cnt_q[AW-1:0];
          out_last_d  = (rd_cnt_q[AW-1:0] == LastIdx);
          out_ovf_d   = ovf_q[rd_bank_q];
          out_valid_d = 1'b1;
          rd_cnt_d    = rd_cnt_q + 1'b1;
        end
      end
      default: rd_d = RdIdle;
    endcase

    free0      = (bank_q[0] == BkFree) || (release_bank && !rd_bank_q);
    free1      = (bank_q[1] == BkFree) || (release_bank && rd_bank_q);
    claim_bank = !free0;

    unique case (cap_q)
      CapIdle: begin
        if (start) begin
          if (free0 || free1) begin
            cap_bank_d         = claim_bank;
            mem_we             = 1'b1;
            mem_wbank          = claim_bank;
            ovf_d[claim_bank]  = samp_ovf;
            cap_cnt_d          = CntOne;
            bank_d[claim_bank] = BkCapt;
            cap_d              = CapCapt;
          end else begin
            cap_cnt_d = CntOne;
            drop_d    = drop_inc;
            cap_d     = CapSkip;
          end
        end
      end
      CapCapt: begin
        if (ED) begin
          mem_we = 1'b1;
          if (RDY) begin
            // A new frame start aborts the partial one in the same bank.
            ovf_d[cap_bank_q] = samp_ovf;
            cap_cnt_d         = CntOne;
          end else begin
            ovf_d[cap_bank_q] = ovf_q[cap_bank_q] | samp_ovf;
            if (cap_cnt_q == LastIdx) begin
              bank_d[cap_bank_q] = BkFull;
              cap_d              = CapIdle;
              if (bank_q[~cap_bank_q] != BkFull) begin
                oldest_d = cap_bank_q;
              end
            end else begin
              cap_cnt_d = cap_cnt_q + 1'b1;
            end
          end
        end
      end
      CapSkip: begin
        if (ED) begin
          if (RDY) begin
            cap_cnt_d = CntOne;
            drop_d    = drop_inc;
          end else if (cap_cnt_q == LastIdx) begin
            cap_d = CapIdle;
          end else begin
            cap_cnt_d = cap_cnt_q + 1'b1;
          end
        end
      end
      default: cap_d = CapIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bank_q[0]   <= BkFree;
      bank_q[1]   <= BkFree;
      cap_q       <= CapIdle;
      cap_bank_q  <= 1'b0;
      cap_cnt_q   <= '0;
      ovf_q       <= '0;
      drop_q      <= '0;
      oldest_q    <= 1'b0;
      rd_q        <= RdIdle;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      cap_q       <= cap_d;
      cap_bank_q  <= cap_bank_d;
      cap_cnt_q   <= cap_cnt_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      oldest_q    <= oldest_d;
      rd_q        <= rd_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_R     = out_r_q;
  assign OUT_I     = out_i_q;
  assign OUT_IDX   = out_idx_q;
  assign OUT_LAST  = out_last_q;
  assign OUT_OVF   = out_ovf_q;
  assign DROP_CNT  = drop_q;
  assign BUSY      = (bank_q[0] != BkFree) || (bank_q[1] != BkFree);

`ifdef FFT_FRAME_BUFFER_MAG_EN
  logic [DW:0] abs_r, abs_i, mag_max, mag_min;

  // Alpha-max/beta-min magnitude; the extra bit holds |most-negative| exactly.
  always_comb begin
    abs_r   = out_r_q[DW-1] ? ({1'b0, ~out_r_q} + 1'b1) : {1'b0, out_r_q};
    abs_i   = out_i_q[DW-1] ? ({1'b0, ~out_i_q} + 1'b1) : {1'b0, out_i_q};
    mag_max = (abs_r > abs_i) ? abs_r : abs_i;
    mag_min = (abs_r > abs_i) ? abs_i : abs_r;
    OUT_MAG = mag_max + (mag_min >> 1);
  end
`endif

endmodule

// File: doc/fft_frame_buffer.md
Name: fft_frame_buffer

Overview:
- Downstream consumer of the 64-point FFT core.
- Captures each output frame (RDY, ED, ADDR, DOR, DOI, OVF1, OVF2) into a two-bank ping-pong buffer.
- Replays each frame in natural bin order (index 0..63) over a valid/ready stream, so back-pressure from later stages never stalls the FFT.
- Drops a frame and counts it when no bank is free.

Parameters:
- DW, 19, width of each real/imag sample (matches the FFT output width)
- AW, 6, bin address width; frame length N = 2**AW = 64
- DCW, 8, width of the dropped-frame counter

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- ED  in  1  FFT data-enable; input qualifiers below are sampled only when ED=1
- RDY  in  1  FFT pulse marking the first output sample of a frame
- ADDR  in  AW  FFT output bin index of the current sample
- DOR  in  DW  FFT output real part, signed
- DOI  in  DW  FFT output imaginary part, signed
- OVF1  in  1  FFT stage-1 overflow
- OVF2  in  1  FFT stage-2 overflow
- OUT_VALID  out  1  output word valid
- OUT_READY  in  1  downstream accepts the word
- OUT_R  out  DW  bin real part
- OUT_I  out  DW  bin imaginary part
- OUT_IDX  out  AW  bin index, 0..63
- OUT_LAST  out  1  high with OUT_IDX=63
- OUT_OVF  out  1  OR of OVF1|OVF2 over the whole captured frame; constant across the frame
- DROP_CNT  out  DCW  saturating count of dropped frames
- BUSY  out  1  at least one bank capturing or full

Behaviour:
- Reset (RST_N=0, any time, including mid-frame): both banks free, capture and replay FSMs idle. Outputs: OUT_VALID=0, OUT_R=0, OUT_I=0, OUT_IDX=0, OUT_LAST=0, OUT_OVF=0, DROP_CNT=0, BUSY=0. Memory contents are don't-care.
- Bank state per bank: FREE -> CAPT -> FULL -> READ -> FREE.
- Capture FSM states: IDLE, CAPT, SKIP.
  - IDLE, on ED&RDY: if a bank is FREE, it becomes CAPT and the first sample is written that cycle; bank 0 has priority when both are FREE. If no bank is FREE, go to SKIP and increment DROP_CNT (saturates at 2**DCW-1).
  - CAPT: every ED=1 cycle writes {DOR,DOI} at ADDR, ORs OVF1|OVF2 into the bank flag, and increments a sample counter. On the 64th write the bank becomes FULL in the next cycle and the FSM returns to IDLE.
  - SKIP: counts 64 ED cycles, then returns to IDLE.
  - ED=0 cycles are ignored in every state.
  - ED&RDY during CAPT: abort the frame. The bank's flag and counter are cleared and capture restarts into the same bank with the current sample. ED&RDY during SKIP restarts the 64-count; DROP_CNT is incremented once more.
- Replay FSM states: IDLE, READ.
  - IDLE: when any bank is FULL, select the oldest FULL bank (tracked by a write-order bit) and go to READ.
  - READ: the read index runs 0..63. The output register loads the word at the current index. OUT_VALID rises one cycle after READ is entered (registered read).
  - Handshake: a word transfers on OUT_VALID&OUT_READY. While OUT_VALID=1 and OUT_READY=0, OUT_R, OUT_I, OUT_IDX, OUT_LAST and OUT_OVF hold stable.
  - Throughput: one word per cycle with OUT_READY held high; there is no bubble between words inside a frame.
  - The transfer with OUT_LAST=1 frees the bank in that cycle.
  - If the other bank is FULL at that point, its index-0 word is presented on the next cycle. This gives a one-cycle OUT_VALID gap between frames.
- Simultaneous free and claim: a bank freed by the OUT_LAST transfer in cycle t may be claimed by ED&RDY in the same cycle t (the free check includes the release).
- Out-of-order ADDR is allowed; storage is by ADDR. If an ADDR repeats within a frame, the last write wins. Bins never written hold stale data; this is not checked.
- BUSY = any bank not FREE.

Optional Feature:
- Macro: FFT_FRAME_BUFFER_MAG_EN.
- Defined:
  - Adds output OUT_MAG, width DW+1, unsigned.
  - OUT_MAG = max(|OUT_R|,|OUT_I|) + (min(|OUT_R|,|OUT_I|) >> 1), alpha-max/beta-min.
  - Computed combinationally from the output registers, so it has the same timing and hold rules as OUT_R.
  - |x| of the most-negative value saturates to 2**(DW-1).
- Not defined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Single frame: ED=1 continuous, RDY at sample 0, ADDR=0..63, DOR=ADDR, DOI=-ADDR, OUT_READY=1 -> 64 words with OUT_IDX=OUT_R=k and OUT_I=-k; OUT_LAST only at k=63; OUT_OVF=0; DROP_CNT=0.
- Bit-reversed ADDR order with DOR=ADDR*3 -> output is in natural order with OUT_R=3*OUT_IDX.
- Three back-to-back frames with OUT_READY=0 -> frames 1 and 2 are stored and frame 3 is dropped (DROP_CNT=1). Then OUT_READY=1 -> frame 1 is fully replayed, then frame 2, in order; BUSY drops only after the second OUT_LAST transfer.
- OVF2=1 on the 10th sample of frame A only -> OUT_OVF=1 on all 64 words of A and 0 on all words of frame B.
- Random OUT_READY (50%) over 4 frames -> no word lost or duplicated; data is stable during stalls; ED=0 gaps in the input do not corrupt the frames.
- RST_N pulsed low at sample 30 of a capture while replay is mid-frame -> outputs return to reset values immediately. The next RDY frame is captured into bank 0 and replayed intact.
